// File: rtl/pulse_period_checker.sv
// Pulse period checker: hunts for a periodic one-clock pulse, locks after LOCK_CNT on-time pulses
// and flags mismatches while locked. Define PULSE_CHK_ERRCNT_EN to build the saturating err_cnt.
module pulse_period_checker #(
    parameter int PERIOD   = 3,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    input  logic       cnt_clr,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int              PH_W     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [7:0]      LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0]      LOSS_TGT = 8'(LOSS_CNT);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [PH_W-1:0] r_ph, w_ph_nxt, w_ph_adv;
    logic [7:0]      r_good, w_good_nxt, w_good_inc;
    logic [7:0]      r_miss, w_miss_nxt, w_miss_inc;
    logic            r_locked, r_err, w_err_nxt;
    logic            w_slot, w_match, w_mismatch;

    assign w_slot     = (r_ph == PH_LAST);
    assign w_match    = din & w_slot;
    assign w_mismatch = din ^ w_slot;
    assign w_ph_adv   = w_slot ? '0 : r_ph + 1'b1;
    assign w_good_inc = r_good + 8'd1;
    assign w_miss_inc = r_miss + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= HUNT;
            r_ph     <= '0;
            r_good   <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ph     <= w_ph_nxt;
            r_good   <= w_good_nxt;
            r_miss   <= w_miss_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_err_nxt   = 1'b0;
        if (en) begin
            unique case (r_state)
                HUNT: begin
                    w_ph_nxt = '0;
                    if (din) begin
                        w_state_nxt = SYNC;
                        w_good_nxt  = 8'd1;
                        w_miss_nxt  = '0;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        w_good_nxt = w_good_inc;
                        w_ph_nxt   = '0;
                        if (w_good_inc == LOCK_TGT) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else if (w_mismatch) begin
                        w_state_nxt = HUNT;
                        w_good_nxt  = '0;
                        w_ph_nxt    = '0;
                    end else begin
                        w_ph_nxt = w_ph_adv;
                    end
                end
                LOCKED: begin
                    // Phase flywheels through misses so a single dropout keeps alignment.
                    w_ph_nxt = w_ph_adv;
                    if (w_match) begin
                        w_miss_nxt = '0;
                    end else if (w_mismatch) begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LOSS_TGT) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                            w_good_nxt  = '0;
                            w_ph_nxt    = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_ph_nxt    = '0;
                end
            endcase
        end
    end

    assign locked = r_locked;
    assign err    = r_err;

`ifdef PULSE_CHK_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Clear wins over a coincident increment; the counter sticks at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = cnt_clr;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker: lock, flywheel, loss, early pulse, enable hold,
// clear, saturation (LOSS_CNT=255 instance) and asynchronous reset.
module tb_pulse_period_checker;

`ifdef PULSE_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       locked, err;
    logic [7:0] err_cnt;
    logic       locked_s, err_s;
    logic [7:0] err_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_period_checker #(.PERIOD(3), .LOCK_CNT(4), .LOSS_CNT(2)) u_dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .cnt_clr(cnt_clr),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    pulse_period_checker #(.PERIOD(3), .LOCK_CNT(4), .LOSS_CNT(255)) u_sat (
        .clk(clk), .rst(rst), .din(din), .en(en), .cnt_clr(cnt_clr),
        .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    // Drive din for the current cycle, then land just after the edge that samples it.
    task automatic tick(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 0);
        chk({tag, "_errcnt_s"}, 32'(err_cnt_s), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        din     = 1'b0;
        en      = 1'b1;
        cnt_clr = 1'b0;
        rst     = 1'b1;
    endtask

    initial begin
        do_reset("RST0");

        // Clean stream: lock after the fourth pulse
        for (int k = 0; k <= 14; k++) begin
            tick((k % 3 == 0) && (k <= 12));
            chk("A_locked", 32'(locked), 32'((k + 1) >= 10));
            chk("A_err", 32'(err), 0);
        end
        chk("A_errcnt", 32'(err_cnt), 0);

        // One missing pulse while locked: single err, lock held
        for (int k = 15; k <= 21; k++) begin
            tick(k == 18 || k == 21);
            chk("A2_err", 32'(err), 32'((k + 1) == 16));
            chk("A2_locked", 32'(locked), 1);
        end
        chk("A2_errcnt", 32'(err_cnt), cnt_exp(1));

        // Two consecutive misses drop lock; re-lock needs four fresh pulses
        do_reset("RSTB");
        for (int k = 0; k <= 31; k++) begin
            int c;
            c = k + 1;
            tick((k % 3 == 0) && (k != 15) && (k != 18));
            chk("B_err", 32'(err), 32'(c == 16 || c == 19));
            chk("B_locked", 32'(locked), 32'((c >= 10 && c <= 18) || c >= 31));
            if (c == 19) chk("B_errcnt", 32'(err_cnt), cnt_exp(2));
        end

        // Early third pulse aborts sync; a later clean train locks
        do_reset("RSTC");
        for (int k = 0; k <= 18; k++) begin
            tick(k == 0 || k == 3 || k == 5 || k == 8 || k == 11 || k == 14 || k == 17);
            chk("C_locked", 32'(locked), 32'((k + 1) >= 18));
            chk("C_err", 32'(err), 0);
        end

        // Double-width pulse, enable hold, clear coincident with an error
        do_reset("RSTD");
        for (int k = 0; k <= 35; k++) begin
            int  c;
            logic d;
            c       = k + 1;
            en      = !(k >= 19 && k <= 22);
            cnt_clr = (k == 31);
            d = ((k % 3 == 0) && k <= 12) || k == 15 || k == 16 || k == 18 ||
                (k >= 19 && k <= 22) || k == 25 || k == 28 || k == 34;
            tick(d);
            chk("D_err", 32'(err), 32'(c == 17 || c == 32));
            chk("D_locked", 32'(locked), 32'(c >= 10));
            if (c == 18 || c == 31) chk("D_errcnt_hold", 32'(err_cnt), cnt_exp(1));
            if (c == 32) chk("D_errcnt_clr", 32'(err_cnt), 0);
        end
        en      = 1'b1;
        cnt_clr = 1'b0;

        // Saturation: 300 misses interleaved with matches on the LOSS_CNT=255 instance
        do_reset("RSTE");
        for (int k = 0; k <= 1809; k++) begin
            int c;
            c = k + 1;
            tick((k % 3 == 0) && !(k >= 12 && k % 6 == 0));
            if (c == 10 || c == 1810) chk("E_locked_s", 32'(locked_s), 1);
            if (c == 67) chk("E_errcnt_mid", 32'(err_cnt_s), cnt_exp(10));
        end
        chk("E_errcnt_sat", 32'(err_cnt_s), cnt_exp(255));
        cnt_clr = 1'b1;
        tick(1'b0);
        cnt_clr = 1'b0;
        chk("E_errcnt_clr", 32'(err_cnt_s), 0);

        // Reset mid-stream while locked, then reacquire
        do_reset("RSTF0");
        for (int k = 0; k <= 16; k++) tick((k % 3 == 0) && (k != 15));
        chk("F_locked_pre", 32'(locked), 1);
        chk("F_errcnt_pre", 32'(err_cnt), cnt_exp(1));
        do_reset("F_async");
        for (int k = 0; k <= 10; k++) begin
            tick(k % 3 == 0);
            chk("F_relock", 32'(locked), 32'((k + 1) >= 10));
        end
        chk("F_errcnt_post", 32'(err_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_period_checker.md
PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

Interface
REQ-001 Parameter PERIOD, default 3: expected pulse spacing in clocks, legal range 2..255.
REQ-002 Parameter LOCK_CNT, default 4: consecutive on-time pulses, first pulse included, needed to declare lock; legal range 2..255.
REQ-003 Parameter LOSS_CNT, default 2: consecutive mismatches while locked that drop lock; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 din  input  1  serial pulse stream under check, one-clock-wide pulses at the generator output.
REQ-007 en  input  1  sample enable; din is evaluated only when high.
REQ-008 cnt_clr  input  1  synchronous clear of err_cnt.
REQ-009 locked  output  1  registered; high while the stream is in lock.
REQ-010 err  output  1  registered; one-clock flag per mismatch detected while locked.
REQ-011 err_cnt  output  8  registered; saturating count of err events.

Function
REQ-012 The FSM SHALL have exactly three states: HUNT, SYNC, LOCKED.
REQ-013 Phase counter ph, width ceil(log2(PERIOD)), SHALL advance by one per enabled cycle and wrap at PERIOD-1 to 0.
REQ-014 A cycle is the "expected slot" when ph==PERIOD-1; a match is din=1 in the expected slot; a mismatch is din=0 in the expected slot or din=1 outside it.
REQ-015 HUNT: ph held at 0; din=1 -> SYNC with ph=0 and good_cnt=1.
REQ-016 SYNC: match -> good_cnt+1 and ph=0; when the incremented good_cnt equals LOCK_CNT -> LOCKED; any mismatch -> HUNT, good_cnt=0.
REQ-017 LOCKED: match -> miss_cnt=0, ph=0; mismatch -> err=1 the following cycle, err_cnt+1, miss_cnt+1; ph continues free-running (flywheel).
REQ-018 LOCKED: when the incremented miss_cnt equals LOSS_CNT -> HUNT, miss_cnt=0, good_cnt=0.
REQ-019 locked SHALL rise the cycle after the lock-completing match and fall the cycle after the loss-completing mismatch.
REQ-020 err_cnt SHALL saturate at 255 and never wrap.
REQ-021 en=0: FSM, ph, good_cnt, miss_cnt and err_cnt hold; din ignored; err=0 next cycle.
REQ-022 cnt_clr=1: err_cnt=0 next cycle; same-cycle error increment is discarded; err itself still pulses.
REQ-023 A double-width pulse (din=1 in the expected slot and the next cycle) SHALL count as one match followed by one mismatch.

Reset
REQ-024 rst=0 SHALL immediately force HUNT, ph=0, good_cnt=0, miss_cnt=0, locked=0, err=0, err_cnt=0, regardless of clk.
REQ-025 Reset released mid-stream SHALL resume in HUNT; lock SHALL be reacquired only after LOCK_CNT further on-time pulses.

Configuration
REQ-026 Macro PULSE_CHK_ERRCNT_EN defined: err_cnt counter and cnt_clr logic per REQ-011, REQ-020, REQ-022.
REQ-027 Macro PULSE_CHK_ERRCNT_EN undefined: err_cnt port present but tied to 0, cnt_clr ignored, no counter flops; all other behaviour identical.

Verification (PERIOD=3, LOCK_CNT=4, LOSS_CNT=2, en=1, macro defined unless stated)
REQ-028 din pulses at cycles 0,3,6,9,12 -> locked=0 through cycle 9, locked=1 from cycle 10, err=0 throughout, err_cnt=0.
REQ-029 Locked stream, pulse at 15 missing, pulse at 18 present -> err=1 at cycle 16 only, err_cnt=1, locked stays 1.
REQ-030 Locked stream, pulses at 15 and 18 missing -> err=1 at 16 and 19, locked=0 from cycle 19, err_cnt=2, FSM in HUNT.
REQ-031 Pulses at 0,3 then 5 (early) -> FSM returns to HUNT at cycle 6, locked never asserts; err stays 0 (not locked).
REQ-032 Force 300 mismatches while locked with LOSS_CNT=255 and a match between each pair of mismatches -> err_cnt saturates at 255; cnt_clr pulse -> err_cnt=0 next cycle.
REQ-033 rst=0 asserted between clock edges while locked -> locked and err_cnt 0 immediately; after release, pulses at 3k resume -> locked again after four pulses; with macro undefined err_cnt=0 in all scenarios.
